// File: rtl/gate_1q_pipe.sv
// Single-qubit gate applier: out = U * (a, b) over complex Q-format values.
// Three stages: operand/matrix capture, 16 real products, sum/round/saturate.
module gate_1q_pipe #(
    parameter int W      = 16,
    parameter int FRAC_D = W - 1,
    parameter int FRAC_C = W - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic signed [W-1:0] ar,
    input  logic signed [W-1:0] ai,
    input  logic signed [W-1:0] br,
    input  logic signed [W-1:0] bi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out0r,
    output logic signed [W-1:0] out0i,
    output logic signed [W-1:0] out1r,
    output logic signed [W-1:0] out1i,
    input  logic                cfg_we,
    input  logic [8*W-1:0]      cfg_u,
    output logic                sat_flag,
    input  logic                sat_clr
);

    localparam int SW    = 2 * W + 2;
    // Products carry FRAC_D+FRAC_C fraction bits; results return to FRAC_D.
    localparam int SHIFT = (FRAC_D + FRAC_C) - FRAC_D;

    function automatic longint inv_sqrt2_q(input int f);
        longint n, r, t;
        n = longint'(1) << (2 * f - 1);
        r = 0;
        for (int b = 23; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= n) r = t;
        end
        if ((2 * r + 1) * (2 * r + 1) <= 4 * n) r = r + 1;
        return r;
    endfunction

    localparam logic signed [W-1:0]  C_ONE     = W'(longint'(1) << FRAC_C);
    localparam logic signed [W-1:0]  C_NEG_ONE = -C_ONE;
    localparam logic signed [W-1:0]  C_H       = W'(inv_sqrt2_q(FRAC_C));
    localparam logic signed [W-1:0]  C_NEG_H   = -C_H;
    localparam logic signed [SW-1:0] RND       = SW'(longint'(1) << (SHIFT - 1));
    localparam logic signed [SW-1:0] SAT_MAX   = SW'((longint'(1) << (W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN   = -SAT_MAX - SW'(1);

    logic                  w_en;
    logic signed [W-1:0]   w_u    [8];
    logic signed [2*W-1:0] w_prod [16];
    logic signed [SW-1:0]  w_sum  [4];
    logic signed [SW-1:0]  w_rnd  [4];
    logic signed [W-1:0]   w_res  [4];
    logic [3:0]            w_sat;

    logic                  r_v1, r_v2, r_v3, r_sat;
    logic [8*W-1:0]        r_shadow;
    logic signed [W-1:0]   r_u1  [8];
    logic signed [W-1:0]   r_x1  [4];
    logic signed [2*W-1:0] r_p2  [16];
    logic signed [W-1:0]   r_out [4];

    assign w_en      = !r_v3 || out_ready;
    assign in_ready  = w_en || !rst_n;
    assign out_valid = r_v3;
    assign sat_flag  = r_sat;
    assign out0r     = rst_n ? r_out[0] : '0;
    assign out0i     = rst_n ? r_out[1] : '0;
    assign out1r     = rst_n ? r_out[2] : '0;
    assign out1i     = rst_n ? r_out[3] : '0;

    // Matrix entry order: u00r,u00i,u01r,u01i,u10r,u10i,u11r,u11i.
    always_comb begin
        for (int i = 0; i < 8; i++) w_u[i] = '0;
        case (in_op)
            3'd0: begin w_u[0] = C_ONE; w_u[6] = C_ONE; end
            3'd1: begin w_u[0] = C_H; w_u[2] = C_H; w_u[4] = C_H; w_u[6] = C_NEG_H; end
            3'd2: begin w_u[2] = C_ONE; w_u[4] = C_ONE; end
            3'd3: begin w_u[3] = C_NEG_ONE; w_u[5] = C_ONE; end
            3'd4: begin w_u[0] = C_ONE; w_u[6] = C_NEG_ONE; end
            3'd5: begin w_u[0] = C_ONE; w_u[7] = C_ONE; end
            3'd6: begin w_u[0] = C_ONE; w_u[6] = C_H; w_u[7] = C_H; end
            default: begin
                for (int i = 0; i < 8; i++) w_u[i] = r_shadow[(7 - i) * W +: W];
            end
        endcase
    end

    // Product gi: output row K, column J, term T in {ur*xr, ui*xi, ur*xi, ui*xr}.
    for (genvar gi = 0; gi < 16; gi++) begin : g_prod
        localparam int K  = gi / 8;
        localparam int J  = (gi / 4) % 2;
        localparam int T  = gi % 4;
        localparam int UI = K * 4 + J * 2 + (((T == 1) || (T == 3)) ? 1 : 0);
        localparam int XI = J * 2 + (((T == 1) || (T == 2)) ? 1 : 0);
        assign w_prod[gi] = (2*W)'(r_u1[UI]) * (2*W)'(r_x1[XI]);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_comp
        localparam int B = (gi / 2) * 8;
        if (gi % 2 == 0) begin : g_re
            assign w_sum[gi] = SW'(r_p2[B]) - SW'(r_p2[B+1]) + SW'(r_p2[B+4]) - SW'(r_p2[B+5]);
        end else begin : g_im
            assign w_sum[gi] = SW'(r_p2[B+2]) + SW'(r_p2[B+3]) + SW'(r_p2[B+6]) + SW'(r_p2[B+7]);
        end
        assign w_rnd[gi] = (w_sum[gi] + RND) >>> SHIFT;
        assign w_sat[gi] = (w_rnd[gi] > SAT_MAX) || (w_rnd[gi] < SAT_MIN);
        assign w_res[gi] = (w_rnd[gi] > SAT_MAX) ? SAT_MAX[W-1:0] :
                           (w_rnd[gi] < SAT_MIN) ? SAT_MIN[W-1:0] : w_rnd[gi][W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_sat    <= 1'b0;
            r_shadow <= '0;
            for (int i = 0; i < 4; i++) r_out[i] <= '0;
        end else begin
            if (cfg_we) r_shadow <= cfg_u;
            if (w_en) begin
                r_v1 <= in_valid;
                r_v2 <= r_v1;
                r_v3 <= r_v2;
                if (r_v2) begin
                    for (int i = 0; i < 4; i++) r_out[i] <= w_res[i];
                end
            end
            if (w_en && r_v2 && (|w_sat)) r_sat <= 1'b1;
            else if (sat_clr)             r_sat <= 1'b0;
        end
    end

    // Datapath registers need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < 8; i++)  r_u1[i] <= w_u[i];
            r_x1[0] <= ar;
            r_x1[1] <= ai;
            r_x1[2] <= br;
            r_x1[3] <= bi;
            for (int i = 0; i < 16; i++) r_p2[i] <= w_prod[i];
        end
    end

endmodule

// File: tb/tb_gate_1q_pipe.sv
// Bench for gate_1q_pipe: directed gate cases plus a randomized stream
// checked against a complex-arithmetic reference model.
`timescale 1ns/1ps
module tb_gate_1q_pipe;

    localparam int W  = 16;
    localparam int FC = W - 2;

    typedef logic signed [W-1:0] amp_t;
    typedef struct packed { amp_t o0r; amp_t o0i; amp_t o1r; amp_t o1i; } res_t;

    logic           clk = 1'b0;
    logic           rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]     in_op;
    amp_t           ar, ai, br, bi, out0r, out0i, out1r, out1i;
    logic           cfg_we, sat_flag, sat_clr;
    logic [8*W-1:0] cfg_u;
    logic [8*W-1:0] m_shadow;

    int   total = 0;
    int   bad   = 0;
    res_t got, exp_r;
    int   lat;
    logic es;

    gate_1q_pipe #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
        .out0r(out0r), .out0i(out0i), .out1r(out1r), .out1i(out1i),
        .cfg_we(cfg_we), .cfg_u(cfg_u), .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    // out_k = u_k0*a + u_k1*b in complex arithmetic, rounded half-up and clamped.
    function automatic res_t model(input logic [2:0] op, input amp_t xar, input amp_t xai,
                                   input amp_t xbr, input amp_t xbi,
                                   input logic [8*W-1:0] sh, output logic sat);
        longint one, c, lim;
        longint u[8];
        longint o[4];
        res_t r;
        one = longint'(1) << FC;
        c   = longint'($rtoi($floor(real'(one) / $sqrt(2.0) + 0.5)));
        lim = (longint'(1) << (W - 1)) - 1;
        for (int i = 0; i < 8; i++) u[i] = 0;
        case (op)
            3'd0: begin u[0] = one; u[6] = one; end
            3'd1: begin u[0] = c; u[2] = c; u[4] = c; u[6] = -c; end
            3'd2: begin u[2] = one; u[4] = one; end
            3'd3: begin u[3] = -one; u[5] = one; end
            3'd4: begin u[0] = one; u[6] = -one; end
            3'd5: begin u[0] = one; u[7] = one; end
            3'd6: begin u[0] = one; u[6] = c; u[7] = c; end
            default: for (int i = 0; i < 8; i++) u[i] = longint'($signed(sh[(7 - i) * W +: W]));
        endcase
        for (int k = 0; k < 2; k++) begin
            o[2*k]   = u[4*k] * xar - u[4*k+1] * xai + u[4*k+2] * xbr - u[4*k+3] * xbi;
            o[2*k+1] = u[4*k] * xai + u[4*k+1] * xar + u[4*k+2] * xbi + u[4*k+3] * xbr;
        end
        sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            o[i] = (o[i] + (one >>> 1)) >>> FC;
            if (o[i] > lim)      begin o[i] = lim;      sat = 1'b1; end
            if (o[i] < -lim - 1) begin o[i] = -lim - 1; sat = 1'b1; end
        end
        r.o0r = amp_t'(o[0]); r.o0i = amp_t'(o[1]);
        r.o1r = amp_t'(o[2]); r.o1i = amp_t'(o[3]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one beat into an empty pipe and waits (bounded) for its result.
    task automatic run_one(input logic [2:0] op, input amp_t xar, input amp_t xai,
                           input amp_t xbr, input amp_t xbi,
                           output res_t r, output int l, output logic s);
        in_op = op; ar = xar; ai = xai; br = xbr; bi = xbi;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 20) begin
            tick();
            l++;
        end
        r = {out0r, out0i, out1r, out1i};
        s = sat_flag;
        $display("beat op=%0d a=(%h,%h) b=(%h,%h) out0=(%h,%h) out1=(%h,%h) lat=%0d sat=%b",
                 op, xar, xai, xbr, xbi, r.o0r, r.o0i, r.o1r, r.o1i, l, s);
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b want=0", sat_flag); end
        total++;
        if ({out0r, out0i, out1r, out1i} !== '0) begin
            bad++; $display("FAIL rst_data got=%h want=0", {out0r, out0i, out1r, out1i});
        end
        rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_h();
        run_one(3'd1, 16'sh4000, 16'sh0, 16'sh0, 16'sh0, got, lat, es);
        total++; if (lat !== 3) begin bad++; $display("FAIL h_latency got=%0d want=3", lat); end
        total++;
        if (got !== {16'sh2D41, 16'sh0, 16'sh2D41, 16'sh0}) begin
            bad++; $display("FAIL h_value got=%h want=2d41_0000_2d41_0000", got);
        end
        total++; if (es !== 1'b0) begin bad++; $display("FAIL h_sat got=%b want=0", es); end
    endtask

    task automatic test_y();
        run_one(3'd3, 16'sh1000, 16'sh0, 16'sh0, 16'sh0, got, lat, es);
        total++;
        if (got !== {16'sh0, 16'sh0, 16'sh0, 16'sh1000}) begin
            bad++; $display("FAIL y_value got=%h want=0000_0000_0000_1000", got);
        end
    endtask

    task automatic test_z_sat();
        run_one(3'd4, 16'sh0, 16'sh0, -16'sh8000, 16'sh0, got, lat, es);
        total++; if (got.o1r !== 16'sh7FFF) begin bad++; $display("FAIL z_out1r got=%h want=7fff", got.o1r); end
        total++;
        if ({got.o0r, got.o0i, got.o1i} !== '0) begin
            bad++; $display("FAIL z_other got=%h want=0", {got.o0r, got.o0i, got.o1i});
        end
        total++; if (es !== 1'b1) begin bad++; $display("FAIL z_sat_set got=%b want=1", es); end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL z_sat_clr got=%b want=0", sat_flag); end
        // clear held across the saturating edge: the set must win
        sat_clr = 1'b1;
        run_one(3'd4, 16'sh0, 16'sh0, -16'sh8000, 16'sh0, got, lat, es);
        sat_clr = 1'b0;
        total++; if (es !== 1'b1) begin bad++; $display("FAIL z_set_wins got=%b want=1", es); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL z_clr_after got=%b want=0", sat_flag); end
    endtask

    task automatic test_rounding();
        cfg_u  = {16'sd1, 112'd0};
        cfg_we = 1'b1;
        tick();
        cfg_we   = 1'b0;
        m_shadow = cfg_u;
        run_one(3'd7, 16'sh2000, 16'sh0, 16'sh0, 16'sh0, got, lat, es);
        total++;
        if (got !== {16'sh0001, 16'sh0, 16'sh0, 16'sh0}) begin
            bad++; $display("FAIL rnd_up got=%h want=0001_0000_0000_0000", got);
        end
        run_one(3'd7, 16'sh1FFF, 16'sh0, 16'sh0, 16'sh0, got, lat, es);
        total++; if (got !== '0) begin bad++; $display("FAIL rnd_down got=%h want=0", got); end
    endtask

    task automatic test_backpressure();
        res_t q[$];
        res_t cur, prev, e;
        logic prev_stall;
        int   sent, recv;
        prev_stall = 1'b0; prev = '0; sent = 0; recv = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = (sent < 6);
            in_op     = 3'd2;
            ar = amp_t'($urandom); ai = amp_t'($urandom);
            br = amp_t'($urandom); bi = amp_t'($urandom);
            out_ready = !(cyc >= 4 && cyc < 9);
            #4;
            cur = {out0r, out0i, out1r, out1i};
            if (out_valid && !out_ready) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
                if (prev_stall) begin
                    total++; if (cur !== prev) begin bad++; $display("FAIL bp_hold got=%h want=%h", cur, prev); end
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra got=%h want=none", cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== e) begin bad++; $display("FAIL bp_data got=%h want=%h", cur, e); end
                    else $display("bp out %0d = %h", recv, cur);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back({br, bi, ar, ai});
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (recv !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", recv); end
    endtask

    task automatic test_random();
        res_t q[$];
        logic sq[$];
        res_t e, cur;
        logic s, drain;
        int   nout;
        nout = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drain     = (cyc >= 360);
            in_valid  = !drain && ($urandom_range(3) != 0);
            in_op     = 3'($urandom_range(7));
            ar = amp_t'($urandom); ai = amp_t'($urandom);
            br = amp_t'($urandom); bi = amp_t'($urandom);
            out_ready = drain || ($urandom_range(3) != 0);
            cfg_we    = !drain && ($urandom_range(7) == 0);
            cfg_u     = {$urandom, $urandom, $urandom, $urandom};
            #4;
            cur = {out0r, out0i, out1r, out1i};
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra got=%h want=none", cur);
                end else begin
                    e = q.pop_front();
                    s = sq.pop_front();
                    if (cur !== e || (s && sat_flag !== 1'b1)) begin
                        bad++; $display("FAIL rand_out%0d got=%h sat=%b want=%h sat>=%b", nout, cur, sat_flag, e, s);
                    end else $display("rand out %0d = %h sat=%b", nout, cur, sat_flag);
                end
                nout++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, ar, ai, br, bi, m_shadow, s));
                sq.push_back(s);
            end
            if (cfg_we) m_shadow = cfg_u;
            tick();
        end
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d want=0 left", q.size()); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op = 3'($urandom_range(6));
            ar = amp_t'($urandom); ai = amp_t'($urandom);
            br = amp_t'($urandom); bi = amp_t'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        m_shadow = '0;
        for (int i = 0; i < 6; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale%0d got=%b want=0", i, out_valid); end
            tick();
        end
        // shadow was cleared by reset, so a CUSTOM beat must produce zero
        run_one(3'd7, 16'sh1234, -16'sh0567, 16'sh0aaa, 16'sh0111, got, lat, es);
        exp_r = model(3'd7, 16'sh1234, -16'sh0567, 16'sh0aaa, 16'sh0111, m_shadow, es);
        total++; if (lat !== 3) begin bad++; $display("FAIL mid_latency got=%0d want=3", lat); end
        total++; if (got !== exp_r) begin bad++; $display("FAIL mid_custom got=%h want=%h", got, exp_r); end
        run_one(3'd0, 16'sh1234, -16'sh0567, 16'sh0aaa, 16'sh0111, got, lat, es);
        exp_r = model(3'd0, 16'sh1234, -16'sh0567, 16'sh0aaa, 16'sh0111, m_shadow, es);
        total++; if (got !== exp_r) begin bad++; $display("FAIL mid_ident got=%h want=%h", got, exp_r); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0;
        ar = '0; ai = '0; br = '0; bi = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_u = '0; sat_clr = 1'b0; m_shadow = '0;
        test_reset();
        test_h();
        test_y();
        test_z_sat();
        test_rounding();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_1q_pipe.md
GATE_1Q_PIPE -- requirements
Module: gate_1q_pipe

Interface
REQ-001 Parameter W, default 16: amplitude and coefficient width in bits, range 8..24.
REQ-002 Parameter FRAC_D, default W-1: amplitude fraction bits; amplitudes are signed Q1.(W-1).
REQ-003 Parameter FRAC_C, default W-2: coefficient fraction bits; coefficients are signed Q2.(W-2), so 1.0 = 2^(W-2).
REQ-004 Ports, in this order:
- clk: input, 1 bit, sole clock, rising edge.
- rst_n: input, 1 bit, synchronous active-low reset.
- in_valid / in_ready: input / output, 1 bit each; input beat handshake.
- in_op: input, 3 bits; gate select.
- ar, ai, br, bi: input, W bits each, signed; amplitude pair a and b.
- out_valid / out_ready: output / input, 1 bit each; output handshake.
- out0r, out0i, out1r, out1i: output, W bits each, signed; results.
- cfg_we: input, 1 bit; loads the custom matrix.
- cfg_u: input, 8*W bits; u00r,u00i,u01r,u01i,u10r,u10i,u11r,u11i, MSB first.
- sat_flag: output, 1 bit; sticky saturation indicator.
- sat_clr: input, 1 bit; clears sat_flag.

Function
REQ-005 Computes out0 = u00*a + u01*b and out1 = u10*a + u11*b as complex arithmetic.
REQ-006 in_op encoding:
- 0 = I.
- 1 = H: all entries c, except u11 = -c; c = round(2^FRAC_C/sqrt2) = 0x2D41 at W=16.
- 2 = X.
- 3 = Y: u01 = -i, u10 = +i.
- 4 = Z.
- 5 = S: u11 = +i.
- 6 = T: u11 = (c,c).
- 7 = CUSTOM: uses the shadow matrix.
REQ-007 Pipeline has 3 register stages.
- S1: registers inputs and the selected matrix.
- S2: registers the 16 real products, each 2W bits.
- S3: registers sums, rounding and saturation.
REQ-008 Each real output component is the sum of 4 products in 2W+2 bits, then rounded half-up: add 2^(FRAC_C-1), then arithmetic right shift by FRAC_C.
REQ-009 The shifted result saturates to the range [-2^(W-1), 2^(W-1)-1].
REQ-010 Global advance enable en = !out_valid || out_ready; all stages move only when en = 1.
REQ-011 in_ready = en, combinational.
REQ-012 A beat is accepted when in_valid && in_ready.
REQ-013 Bubbles propagate as cleared per-stage valid bits.
REQ-014 Latency: a beat accepted at edge N with out_ready held high gives out_valid = 1 after edge N+3; throughput is 1 beat per cycle.
REQ-015 While out_valid && !out_ready, all stages and outputs hold stable and no beat is accepted or lost.
REQ-016 Output order equals acceptance order.
REQ-017 in_op is sampled with its beat; mixing ops on consecutive beats is legal.
REQ-018 On cfg_we, the shadow matrix <= cfg_u.
- A beat accepted in the same cycle uses the previous shadow matrix.
- CUSTOM beats already in flight are unaffected by the load.
REQ-019 sat_flag sets when any S3 component of an advancing valid beat saturates.
REQ-020 sat_clr clears sat_flag; a set event in the same cycle wins.
REQ-021 Saturation example: Z with b = -1.0 (0x8000 at W=16) yields out1r = 0x7FFF and sets sat_flag.

Reset
REQ-022 On a clk edge with rst_n = 0, the following clear to 0: all stage valids, out_valid, sat_flag, and the shadow matrix.
REQ-023 During reset, in_ready = 1 and the data outputs read 0.
REQ-024 Reset asserted mid-stream discards all in-flight beats; after release, no stale beat appears on the output.

Verification
REQ-025 H test: a = (0x4000,0), b = 0 -> out0 = (0x2D41,0), out1 = (0x2D41,0), latency 3, sat_flag = 0.
REQ-026 Z test: b = (0x8000,0) -> out1r = 0x7FFF, sat_flag = 1; then sat_clr -> 0.
REQ-027 Y test: a = (0x1000,0), b = 0 -> out0 = 0, out1 = (0,0x1000).
REQ-028 Rounding test: CUSTOM load with u00 = (1,0) and all other entries 0; a = (0x2000,0) -> out0r = 0x0001; a = (0x1FFF,0) -> out0r = 0x0000.
REQ-029 Backpressure test: stream 6 beats of X with out_ready low for 5 cycles mid-stream -> in_ready drops, outputs hold stable, all 6 outputs arrive in order and equal (b,a).
REQ-030 Reset test: assert rst_n = 0 for 1 cycle with 3 beats in flight -> out_valid = 0 and no stale output afterwards; the next accepted beat appears 3 cycles later.
